pipe_control: RTL and testbench

- Central pipeline-register controller for the Y86-64 five-stage pipeline.
- Merges per-cycle hazard requests (load-use, ret, mispredict), data-memory wait and exception status from M/W into one stall/bubble vector for the F, D, E, M and W pipeline registers.
- Sequences the post-reset flush, the exception drain and the halt.
- Keeps saturating performance counters.

---
 rtl/y86_pkg.sv | 24 ++
 rtl/pipe_perf_cnt.sv | 22 ++
 rtl/pipe_control.sv | 196 +++++++++++++++++++
 tb/tb_pipe_control.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions.
//   - status codes carried with each instruction through the pipe
//   - icode values used by the hazard detector feeding pipe_control
//   - pipe_control FSM state type
package y86_pkg;

    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;

    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_EXC,
        ST_HALT
    } pc_state_e;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating performance counter.
//   clk  : clock
//   clr  : synchronous clear (wins over inc)
//   inc  : count enable
//   cnt  : current value, sticks at all-ones
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipe_control.sv
// Y86-64 pipeline-register controller.
// Merges hazard requests, data-memory wait and M/W exception status into
// stall/bubble controls for F..W, sequences the post-reset flush, the
// exception drain and the halt, and keeps saturating perf counters.
//   clk, rst                  : clock, synchronous active-high reset
//   load_use_req, ret_req,
//   mispredict_req, dmem_busy : per-cycle hazard / wait requests
//   m_stat, W_stat            : status leaving M / held in W
//   *_stall, *_bubble         : pipeline register controls (combinational)
//   set_cc_en                 : CC write enable for E
//   halted, halt_stat         : frozen flag and the stat that froze it
//   cycle_cnt, stall_cnt,
//   bubble_cnt                : saturating perf counters
module pipe_control
    import y86_pkg::*;
#(
    parameter int INIT_BUBBLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_req,
    input  logic             ret_req,
    input  logic             mispredict_req,
    input  logic             dmem_busy,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             E_stall,
    output logic             M_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_bubble,
    output logic             set_cc_en,
    output logic             halted,
    output logic [3:0]       halt_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int FW = (INIT_BUBBLES > 1) ? $clog2(INIT_BUBBLES) : 1;

    pc_state_e     state, state_nxt;
    logic [FW-1:0] flush_cnt, flush_nxt;
    logic          halt_go;

    // Any value other than AOK (including undefined codes) is a fault.
    wire m_bad = (m_stat != STAT_AOK);
    wire w_bad = (W_stat != STAT_AOK);

    always_comb begin
        F_stall   = 1'b0;
        D_stall   = 1'b0;
        E_stall   = 1'b0;
        M_stall   = 1'b0;
        W_stall   = 1'b0;
        D_bubble  = 1'b0;
        E_bubble  = 1'b0;
        M_bubble  = 1'b0;
        W_bubble  = 1'b0;
        set_cc_en = 1'b0;
        halted    = 1'b0;
        halt_go   = 1'b0;
        state_nxt = state;
        flush_nxt = flush_cnt;

        if (rst) begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_bubble = 1'b1;
        end else begin
            unique case (state)
                ST_INIT: begin
                    F_stall  = 1'b1;
                    D_bubble = 1'b1;
                    E_bubble = 1'b1;
                    M_bubble = 1'b1;
                    W_bubble = 1'b1;
                    if (flush_cnt == '0)
                        state_nxt = ST_RUN;
                    else
                        flush_nxt = flush_cnt - 1'b1;
                end
                ST_RUN: begin
                    if (w_bad) begin
                        // Faulting instruction reached W: freeze it there.
                        halt_go   = 1'b1;
                        state_nxt = ST_HALT;
                        F_stall   = 1'b1;
                        D_stall   = 1'b1;
                        W_stall   = 1'b1;
                        E_bubble  = 1'b1;
                        M_bubble  = 1'b1;
                    end else if (m_bad) begin
                        // Keep younger instructions out of M so no store
                        // behind the fault commits; fetch keeps going.
                        state_nxt = ST_EXC;
                        M_bubble  = 1'b1;
                    end else if (dmem_busy) begin
                        F_stall  = 1'b1;
                        D_stall  = 1'b1;
                        E_stall  = 1'b1;
                        M_stall  = 1'b1;
                        W_bubble = 1'b1;
                    end else if (load_use_req) begin
                        F_stall  = 1'b1;
                        D_stall  = 1'b1;
                        E_bubble = 1'b1;
                    end else if (mispredict_req) begin
                        D_bubble = 1'b1;
                        E_bubble = 1'b1;
                    end else if (ret_req) begin
                        F_stall  = 1'b1;
                        D_bubble = 1'b1;
                    end else begin
                        set_cc_en = 1'b1;
                    end
                end
                ST_EXC: begin
                    if (w_bad) begin
                        halt_go   = 1'b1;
                        state_nxt = ST_HALT;
                        F_stall   = 1'b1;
                        D_stall   = 1'b1;
                        W_stall   = 1'b1;
                        E_bubble  = 1'b1;
                        M_bubble  = 1'b1;
                    end else if (dmem_busy) begin
                        // Fault still stuck in M: hold it rather than bubble it.
                        F_stall  = 1'b1;
                        D_stall  = 1'b1;
                        E_stall  = 1'b1;
                        M_stall  = 1'b1;
                        W_bubble = 1'b1;
                    end else begin
                        M_bubble = 1'b1;
                    end
                end
                ST_HALT: begin
                    halted   = 1'b1;
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    W_stall  = 1'b1;
                    E_bubble = 1'b1;
                    M_bubble = 1'b1;
                end
                default: state_nxt = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            flush_cnt <= FW'(INIT_BUBBLES - 1);
            halt_stat <= 4'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_nxt;
            if (halt_go)
                halt_stat <= W_stat;
        end
    end

    // Stall/bubble activity is only counted while real instructions flow.
    wire active     = !rst && ((state == ST_RUN) || (state == ST_EXC));
    wire any_bubble = D_bubble | E_bubble | M_bubble | W_bubble;

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .clr (rst),
        .inc (state != ST_HALT),
        .cnt (cycle_cnt)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (active && F_stall),
        .cnt (stall_cnt)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .clr (rst),
        .inc (active && any_bubble),
        .cnt (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: a 32-bit-counter instance and a 4-bit
// counter instance share one stimulus stream; control vectors and counter
// values are checked against expectations queued when each step is driven.
module tb_pipe_control;

    logic       clk = 1'b0;
    logic       rst, load_use_req, ret_req, mispredict_req, dmem_busy;
    logic [3:0] m_stat, W_stat;

    logic        F_stall, D_stall, E_stall, M_stall, W_stall;
    logic        D_bubble, E_bubble, M_bubble, W_bubble, set_cc_en, halted;
    logic [3:0]  halt_stat;
    logic [31:0] cycle_cnt, stall_cnt, bubble_cnt;

    logic        F4s, D4s, E4s, M4s, W4s, D4b, E4b, M4b, W4b, cc4, h4;
    logic [3:0]  hs4, cyc4, stl4, bub4;

    always #5 clk = ~clk;

    pipe_control #(.INIT_BUBBLES(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .load_use_req(load_use_req), .ret_req(ret_req),
        .mispredict_req(mispredict_req), .dmem_busy(dmem_busy),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall),
        .M_stall(M_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .W_bubble(W_bubble), .set_cc_en(set_cc_en), .halted(halted),
        .halt_stat(halt_stat), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    pipe_control #(.INIT_BUBBLES(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .load_use_req(load_use_req), .ret_req(ret_req),
        .mispredict_req(mispredict_req), .dmem_busy(dmem_busy),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F4s), .D_stall(D4s), .E_stall(E4s), .M_stall(M4s), .W_stall(W4s),
        .D_bubble(D4b), .E_bubble(E4b), .M_bubble(M4b), .W_bubble(W4b),
        .set_cc_en(cc4), .halted(h4), .halt_stat(hs4),
        .cycle_cnt(cyc4), .stall_cnt(stl4), .bubble_cnt(bub4)
    );

    // {F,D,E,M,W stall, D,E,M,W bubble, set_cc_en, halted}
    wire [10:0] ctl = {F_stall, D_stall, E_stall, M_stall, W_stall,
                       D_bubble, E_bubble, M_bubble, W_bubble, set_cc_en, halted};

    localparam logic [10:0] V_INIT    = 11'b10000_1111_0_0;
    localparam logic [10:0] V_RUN     = 11'b00000_0000_1_0;
    localparam logic [10:0] V_LU      = 11'b11000_0100_0_0;
    localparam logic [10:0] V_MP      = 11'b00000_1100_0_0;
    localparam logic [10:0] V_RET     = 11'b10000_1000_0_0;
    localparam logic [10:0] V_BUSY    = 11'b11110_0001_0_0;
    localparam logic [10:0] V_EXC     = 11'b00000_0010_0_0;
    localparam logic [10:0] V_HALTING = 11'b11001_0110_0_0;
    localparam logic [10:0] V_HALT    = 11'b11001_0110_0_1;

    int tests = 0;
    int fails = 0;

    logic [10:0] sb[$];
    int  ncyc = 0, nstall = 0, nbub = 0;
    bit  ck = 1'b0;

    function automatic logic [63:0] sat4(input int n);
        return (n > 15) ? 64'd15 : 64'(n);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, queue expected control vector, compare
    // at the falling edge, then advance the counter model for this cycle.
    // act marks cycles spent in RUN/EXC, where stall/bubble counting applies.
    task automatic cyc(input string tag, input bit r, input bit lu, input bit rt,
                       input bit mp, input bit busy, input logic [3:0] ms,
                       input logic [3:0] ws, input logic [10:0] ev, input bit act);
        logic [10:0] e;
        rst = r; load_use_req = lu; ret_req = rt; mispredict_req = mp;
        dmem_busy = busy; m_stat = ms; W_stat = ws;
        sb.push_back(ev);
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, "/ctl"}, 64'(ctl), 64'(e));
        if (ck) begin
            chk({tag, "/cycle_cnt"},  64'(cycle_cnt),  64'(ncyc));
            chk({tag, "/stall_cnt"},  64'(stall_cnt),  64'(nstall));
            chk({tag, "/bubble_cnt"}, 64'(bubble_cnt), 64'(nbub));
            chk({tag, "/cycle_cnt4"}, 64'(cyc4), sat4(ncyc));
            chk({tag, "/stall_cnt4"}, 64'(stl4), sat4(nstall));
            chk({tag, "/bubble_cnt4"},64'(bub4), sat4(nbub));
        end
        if (r) begin
            ncyc = 0; nstall = 0; nbub = 0; ck = 1'b1;
        end else begin
            if (!e[0]) ncyc++;
            if (act) begin
                if (e[10])   nstall++;
                if (|e[5:2]) nbub++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [3:0] OK = 4'd1;

    initial begin
        // reset held 3 cycles, then 4 flush cycles with requests ignored
        for (int i = 0; i < 3; i++) cyc("rst", 1, 0, 0, 0, 0, OK, OK, V_INIT, 0);
        for (int i = 0; i < 4; i++) cyc("init", 0, 1, 1, 1, 0, OK, OK, V_INIT, 0);
        cyc("run", 0, 0, 0, 0, 0, OK, OK, V_RUN, 1);

        // hazard priorities
        cyc("lu_ret", 0, 1, 1, 0, 0, OK, OK, V_LU,  1);
        cyc("ret",    0, 0, 1, 0, 0, OK, OK, V_RET, 1);
        cyc("mp_ret", 0, 0, 1, 1, 0, OK, OK, V_MP,  1);
        cyc("idle",   0, 0, 0, 0, 0, OK, OK, V_RUN, 1);

        // dmem wait outranks load-use
        for (int i = 0; i < 3; i++) cyc("busy_lu", 0, 1, 0, 0, 1, OK, OK, V_BUSY, 1);
        cyc("lu", 0, 1, 0, 0, 0, OK, OK, V_LU, 1);

        // ADR fault in M, reaches W next cycle, then frozen
        cyc("m_adr", 0, 0, 0, 0, 0, 4'd3, OK,   V_EXC,     1);
        cyc("w_adr", 0, 0, 0, 0, 0, OK,   4'd3, V_HALTING, 1);
        chk("halt_stat_adr", 64'(halt_stat), 64'd3);
        for (int i = 0; i < 3; i++) cyc("halt", 0, 1, 1, 0, 0, OK, 4'd3, V_HALT, 0);
        chk("halt_stat_hold", 64'(halt_stat), 64'd3);

        // reset out of HALT
        cyc("rst2", 1, 0, 0, 0, 0, OK, OK, V_INIT, 0);
        chk("halt_stat_rst", 64'(halt_stat), 64'd0);
        for (int i = 0; i < 4; i++) cyc("init2", 0, 0, 0, 0, 0, OK, OK, V_INIT, 0);

        // long ret run drives the 4-bit counters into saturation
        for (int i = 0; i < 20; i++) cyc("ret_sat", 0, 0, 1, 0, 0, OK, OK, V_RET, 1);
        chk("stall_cnt4_sat", 64'(stl4), 64'd15);

        // unknown m_stat enters EXC; dmem wait there holds M; requests ignored
        cyc("m_unk",    0, 0, 0, 0, 0, 4'd7, OK,   V_EXC,     1);
        cyc("exc_busy", 0, 1, 0, 0, 1, OK,   OK,   V_BUSY,    1);
        cyc("exc",      0, 1, 1, 1, 0, OK,   OK,   V_EXC,     1);
        cyc("w_ins",    0, 0, 0, 0, 0, OK,   4'd4, V_HALTING, 1);
        chk("halt_stat_ins", 64'(halt_stat), 64'd4);
        cyc("halt2",    0, 0, 0, 0, 0, OK,   4'd4, V_HALT,    0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
